tile_coord_loader: RTL

- Front-end writer for the tile-pair area engine: parses an ASCII byte stream of "x,y" lines into binary coordinate pairs.
- Writes each pair into the engine's X/Y coordinate memories through a single write port.
- Reports the element count, so coordinates arrive from a stream rather than preloaded memory files.
- Sits between the byte-stream source (UART/DMA) and the coordinate RAMs.

---
 rtl/tile_coord_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/tile_coord_loader.sv
// Parses an ASCII "x,y\n" byte stream into binary coordinate pairs and writes them to the X/Y memories.
// Optional running sum of committed x+y values on the checksum port when TILE_LOADER_CHECKSUM_EN is defined.
module tile_coord_loader #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned MAX_ELEMENTS = 496,
   parameter int unsigned ADDR_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_x,
   output logic [DATA_WIDTH-1:0] wr_y,
   output logic [ADDR_WIDTH-1:0] count,
   output logic                  done,
   output logic                  error
`ifdef TILE_LOADER_CHECKSUM_EN
   ,
   output logic [63:0]           checksum
`endif
);

   localparam int unsigned EXT_W = DATA_WIDTH + 4;

   typedef enum logic [2:0] {IDLE, PARSE_X, PARSE_Y, DONE, ERR} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] acc_x;
   logic [DATA_WIDTH-1:0] acc_y;
   logic                  seen_x;
   logic                  seen_y;

   logic                  accept_c;
   logic                  is_digit_c;
   logic                  is_ws_c;
   logic                  full_c;
   logic [3:0]            digit_c;
   logic [EXT_W-1:0]      mac_c;
   logic                  mac_ovf_c;
   logic [DATA_WIDTH-1:0] mac_val_c;

   // Decimal accumulate with 4 spare bits so any overflow past DATA_WIDTH is visible
   assign accept_c   = in_valid && in_ready;
   assign is_digit_c = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign is_ws_c    = (in_data == 8'h0d) || (in_data == 8'h20);
   assign digit_c    = 4'(in_data - 8'h30);
   assign mac_c      = EXT_W'((state == PARSE_Y) ? acc_y : acc_x) * EXT_W'(10) + EXT_W'(digit_c);
   assign mac_ovf_c  = |mac_c[EXT_W-1:DATA_WIDTH];
   assign mac_val_c  = mac_c[DATA_WIDTH-1:0];
   assign full_c     = (count == ADDR_WIDTH'(MAX_ELEMENTS));

   logic                  ld_x_c;
   logic                  ld_y_c;
   logic                  to_y_c;
   logic                  commit_c;
   logic [DATA_WIDTH-1:0] commit_y_c;
   logic                  line_end_c;
   logic                  to_done_c;
   logic                  to_err_c;

   // Per-byte decode: what the accepted byte does to accumulators, commit and state
   always_comb begin
      ld_x_c     = 1'b0;
      ld_y_c     = 1'b0;
      to_y_c     = 1'b0;
      commit_c   = 1'b0;
      commit_y_c = acc_y;
      line_end_c = 1'b0;
      to_done_c  = 1'b0;
      to_err_c   = 1'b0;
      if (accept_c) begin
         if (state == PARSE_X) begin
            if (is_digit_c) begin
               if (mac_ovf_c || in_last) to_err_c = 1'b1;
               else                      ld_x_c   = 1'b1;
            end else if (in_data == 8'h2c) begin
               if (!seen_x || in_last) to_err_c = 1'b1;
               else                    to_y_c   = 1'b1;
            end else if (is_ws_c || (in_data == 8'h0a && !seen_x)) begin
               if (in_last) begin
                  if (seen_x) to_err_c  = 1'b1;
                  else        to_done_c = 1'b1;
               end
            end else begin
               to_err_c = 1'b1;
            end
         end else if (state == PARSE_Y) begin
            if (is_digit_c) begin
               if (mac_ovf_c) begin
                  to_err_c = 1'b1;
               end else begin
                  ld_y_c = 1'b1;
                  if (in_last) begin
                     commit_c   = 1'b1;
                     commit_y_c = mac_val_c;
                     to_done_c  = 1'b1;
                  end
               end
            end else if (in_data == 8'h0a) begin
               if (!seen_y) begin
                  to_err_c = 1'b1;
               end else begin
                  commit_c   = 1'b1;
                  line_end_c = 1'b1;
                  to_done_c  = in_last;
               end
            end else if (is_ws_c) begin
               if (in_last) begin
                  if (seen_y) begin
                     commit_c  = 1'b1;
                     to_done_c = 1'b1;
                  end else begin
                     to_err_c = 1'b1;
                  end
               end
            end else begin
               to_err_c = 1'b1;
            end
         end
         // A full memory turns the commit into a capacity fault with no write
         if (commit_c && full_c) begin
            commit_c  = 1'b0;
            to_done_c = 1'b0;
            to_err_c  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_x     <= '0;
         wr_y     <= '0;
         count    <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
         acc_x    <= '0;
         acc_y    <= '0;
         seen_x   <= 1'b0;
         seen_y   <= 1'b0;
`ifdef TILE_LOADER_CHECKSUM_EN
         checksum <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= PARSE_X;
                  in_ready <= 1'b1;
                  count    <= '0;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  acc_x    <= '0;
                  acc_y    <= '0;
                  seen_x   <= 1'b0;
                  seen_y   <= 1'b0;
`ifdef TILE_LOADER_CHECKSUM_EN
                  checksum <= '0;
`endif
               end
            end
            PARSE_X, PARSE_Y: begin
               if (ld_x_c) begin
                  acc_x  <= mac_val_c;
                  seen_x <= 1'b1;
               end
               if (ld_y_c) begin
                  acc_y  <= mac_val_c;
                  seen_y <= 1'b1;
               end
               if (to_y_c) state <= PARSE_Y;
               if (commit_c) begin
                  wr_en   <= 1'b1;
                  wr_addr <= count;
                  wr_x    <= acc_x;
                  wr_y    <= commit_y_c;
                  count   <= count + ADDR_WIDTH'(1);
`ifdef TILE_LOADER_CHECKSUM_EN
                  checksum <= checksum + 64'(acc_x) + 64'(commit_y_c);
`endif
               end
               if (line_end_c) begin
                  state  <= PARSE_X;
                  acc_x  <= '0;
                  acc_y  <= '0;
                  seen_x <= 1'b0;
                  seen_y <= 1'b0;
               end
               if (to_err_c) begin
                  state    <= ERR;
                  error    <= 1'b1;
                  in_ready <= 1'b0;
               end else if (to_done_c) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  in_ready <= 1'b0;
               end
            end
            DONE, ERR: begin
               if (!start) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
